itcm_ctrl: RTL and testbench
============================

Name: itcm_ctrl

Overview:
Instruction tightly-coupled memory controller. It sits directly upstream of the fetch stage and serves its ifu_req/ifu_rsp valid-ready channels, plus a second request port for load/store access to the same memory. It arbitrates between the two ports and drives a single-port synchronous SRAM with 1-cycle read latency. A one-entry holding buffer absorbs response backpressure.

Parameters:
PC_SIZE, 32, width of fetch PC and LSU byte address
DW, 32, data/instruction width (equals `INSTR_SIZE)
RAM_AW, 12, SRAM word-address width; ITCM size = 4*2^RAM_AW bytes, based at address 0
STARVE_MAX, 2, consecutive LSU grants allowed while IFU waits

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ifu_req_valid  in  1  fetch request valid
ifu_req_ready  out  1  fetch request accepted
ifu_req_pc  in  PC_SIZE  fetch byte address
ifu_rsp_valid  out  1  fetch response valid
ifu_rsp_ready  in  1  fetch stage accepts response
ifu_rsp_instr  out  DW  fetched instruction
ifu_rsp_err  out  1  fetch address out of range or misaligned
lsu_req_valid  in  1  LSU request valid
lsu_req_ready  out  1  LSU request accepted
lsu_req_addr  in  PC_SIZE  LSU byte address
lsu_req_write  in  1  1=write, 0=read
lsu_req_wdata  in  DW  write data
lsu_req_wmask  in  DW/8  byte write enables
lsu_rsp_valid  out  1  LSU response valid
lsu_rsp_ready  in  1  LSU accepts response
lsu_rsp_rdata  out  DW  read data (0 for writes and errors)
lsu_rsp_err  out  1  LSU address error
ram_cs  out  1  SRAM chip select
ram_we  out  1  SRAM write enable
ram_addr  out  RAM_AW  SRAM word address
ram_wem  out  DW/8  SRAM byte write mask
ram_din  out  DW  SRAM write data
ram_dout  in  DW  SRAM read data, valid the cycle after ram_cs with ram_we=0

Behaviour:
- Clock is clk. Reset is rst_n, asynchronous and active-low. Reset clears the state to IDLE, owner to IFU, the hold register to 0, and the streak counter to 0. While rst_n=0: ram_cs=0, both rsp_valid=0, both req_ready=0.
- States:
  - IDLE: no transaction in flight.
  - RSP: the SRAM access was issued last cycle; the response is driven from ram_dout.
  - HOLD: the response was not accepted; it is driven from the hold register.
- Only one transaction is outstanding. An owner flag routes the response to the IFU or LSU port. The other port's rsp_valid is 0.
- Issue condition: state==IDLE, or (state in RSP/HOLD and the owning port's rsp_valid&rsp_ready this cycle). req_ready is high only for the granted port under the issue condition. A grant issues the SRAM access in the same cycle (ram_cs=1 only if the address is legal) and moves to RSP next cycle. With no grant, the state goes to IDLE.
- Back-to-back throughput is 1 transaction/cycle when the response is accepted each cycle.
- RSP with rsp_ready=0: capture ram_dout, err, and rdata into the hold register and go to HOLD. Captured data is 0 for writes and errors. HOLD persists until accepted.
- Arbitration: LSU has priority, with a starvation guard. When the IFU is valid and loses, streak increments (saturating). When streak==STARVE_MAX and the IFU is valid, the IFU wins. streak clears on an IFU grant or when ifu_req_valid=0.
- Legality:
  - An address is illegal if addr[PC_SIZE-1:RAM_AW+2]!=0 or addr[1:0]!=0.
  - An illegal request is accepted normally. It causes no SRAM access. Its response appears next cycle with err=1 and data 0.
  - ram_addr=addr[RAM_AW+1:2].
- Writes: ram_we=1, ram_wem=wmask, ram_din=wdata. The response comes next cycle with rdata=0, err=0. A wmask of all zeros still counts as a legal access with no byte change.
- Response data/instr outputs equal 0 when the corresponding valid=0.
- Asynchronous reset mid-transaction drops the in-flight response. No response is produced after reset release.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with ifu_req_valid=1 -> all valids, readies, and ram_cs are 0. After release, the first IFU request at pc=0x4 gives ram_addr=1 and ram_cs=1, and ifu_rsp_instr equals the RAM word 1 model value one cycle later.
- Streaming fetch: ifu_rsp_ready=1, pc=0x0,0x4,0x8 on consecutive cycles -> ifu_req_ready=1 every cycle, and 3 responses on 3 consecutive cycles in order.
- Backpressure: a fetch of 0x10 with ifu_rsp_ready=0 for 4 cycles -> ifu_rsp_valid stays 1 with a stable instr. ram_cs=0 and ifu_req_ready=0 during the stall. The response is accepted on the 5th cycle.
- Contention: both ports valid every cycle with STARVE_MAX=2 -> grant sequence is LSU, LSU, IFU, LSU, LSU, IFU.
- Errors: a fetch at 0x0000_4000 (RAM_AW=12) and an LSU read at 0x6 -> no ram_cs; the responses carry err=1 and data 0.
- Write/read: LSU writes 0xAABBCCDD with wmask=4'b0101 to 0x20, whose RAM model holds 0x11223344 -> a later read of 0x20 returns 0x11BB33DD, and the write response has rdata=0 and err=0.

Source files
------------

// File: rtl/itcm_ctrl.sv
// itcm_ctrl: instruction tightly-coupled memory controller.
//
// Serves a fetch port (ifu_req/ifu_rsp) and a load/store port (lsu_req/lsu_rsp)
// through one single-port synchronous SRAM with 1-cycle read latency. Only one
// transaction is outstanding. A one-entry hold register keeps a response that
// was not accepted. The LSU has priority, but after STARVE_MAX consecutive LSU
// wins against a waiting IFU, the IFU is granted.
//
// Ports:
//   clk, rst_n                 clock (rising edge), async active-low reset
//   ifu_req_valid/ready/pc     fetch request channel (byte address)
//   ifu_rsp_valid/ready        fetch response channel
//   ifu_rsp_instr/err          fetched word, range/alignment error
//   lsu_req_valid/ready        load/store request channel
//   lsu_req_addr/write         byte address, 1 = write
//   lsu_req_wdata/wmask        write data and byte enables
//   lsu_rsp_valid/ready        load/store response channel
//   lsu_rsp_rdata/err          read data (0 for writes/errors), address error
//   ram_cs/we/addr/wem/din     SRAM command (word address, byte mask)
//   ram_dout                   SRAM read data, valid one cycle after a read
module itcm_ctrl #(
    parameter int PC_SIZE    = 32,
    parameter int DW         = 32,
    parameter int RAM_AW     = 12,
    parameter int STARVE_MAX = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ifu_req_valid,
    output logic                ifu_req_ready,
    input  logic [PC_SIZE-1:0]  ifu_req_pc,
    output logic                ifu_rsp_valid,
    input  logic                ifu_rsp_ready,
    output logic [DW-1:0]       ifu_rsp_instr,
    output logic                ifu_rsp_err,
    input  logic                lsu_req_valid,
    output logic                lsu_req_ready,
    input  logic [PC_SIZE-1:0]  lsu_req_addr,
    input  logic                lsu_req_write,
    input  logic [DW-1:0]       lsu_req_wdata,
    input  logic [DW/8-1:0]     lsu_req_wmask,
    output logic                lsu_rsp_valid,
    input  logic                lsu_rsp_ready,
    output logic [DW-1:0]       lsu_rsp_rdata,
    output logic                lsu_rsp_err,
    output logic                ram_cs,
    output logic                ram_we,
    output logic [RAM_AW-1:0]   ram_addr,
    output logic [DW/8-1:0]     ram_wem,
    output logic [DW-1:0]       ram_din,
    input  logic [DW-1:0]       ram_dout
);

    localparam int MW = DW / 8;
    localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RSP  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Legal = inside the ITCM window starting at 0 and word aligned.
    function automatic logic addr_legal(input logic [PC_SIZE-1:0] a);
        return ((a >> (RAM_AW + 2)) == '0) && (a[1:0] == 2'b00);
    endfunction

    state_t             state_p1;
    state_t             state_nxt;
    logic               owner_p1;      // 0 = IFU, 1 = LSU
    logic               err_p1;
    logic               zero_p1;       // response data forced to 0 (write or error)
    logic [DW-1:0]      hold_data_p2;
    logic               hold_err_p2;
    logic [SW-1:0]      streak;

    logic               vld_p1;
    logic               rsp_ready_sel;
    logic               issue;
    logic               lsu_win;
    logic               grant_ifu;
    logic               grant_lsu;
    logic [PC_SIZE-1:0] sel_addr;
    logic               sel_legal;
    logic [DW-1:0]      rsp_data;
    logic               rsp_err;

    // ---- stage p0: arbitration and SRAM issue ----
    assign vld_p1        = (state_p1 != IDLE);
    assign rsp_ready_sel = owner_p1 ? lsu_rsp_ready : ifu_rsp_ready;
    // rst_n gating keeps every ready and ram_cs low while reset is asserted.
    assign issue         = rst_n && (!vld_p1 || rsp_ready_sel);
    assign lsu_win       = lsu_req_valid && !(ifu_req_valid && (streak == STREAK_MAX));
    assign grant_lsu     = issue && lsu_win;
    assign grant_ifu     = issue && ifu_req_valid && !lsu_win;
    assign sel_addr      = grant_lsu ? lsu_req_addr : ifu_req_pc;
    assign sel_legal     = addr_legal(sel_addr);

    assign ifu_req_ready = grant_ifu;
    assign lsu_req_ready = grant_lsu;

    always_comb begin
        state_nxt = IDLE;
        ram_cs    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = sel_addr[RAM_AW+1:2];
        ram_wem   = '0;
        ram_din   = '0;
        if (grant_ifu || grant_lsu) begin
            state_nxt = RSP;
            ram_cs    = sel_legal;
            if (sel_legal && grant_lsu && lsu_req_write) begin
                ram_we  = 1'b1;
                ram_wem = lsu_req_wmask;
                ram_din = lsu_req_wdata;
            end
        end else if (vld_p1 && !rsp_ready_sel) begin
            state_nxt = HOLD;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_p1 <= IDLE;
        end else begin
            state_p1 <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_p1     <= 1'b0;
            err_p1       <= 1'b0;
            zero_p1      <= 1'b0;
            hold_data_p2 <= '0;
            hold_err_p2  <= 1'b0;
            streak       <= '0;
        end else begin
            if (grant_ifu || grant_lsu) begin
                owner_p1 <= grant_lsu;
                err_p1   <= !sel_legal;
                zero_p1  <= !sel_legal || (grant_lsu && lsu_req_write);
            end
            if ((state_p1 == RSP) && !rsp_ready_sel) begin
                hold_data_p2 <= rsp_data;
                hold_err_p2  <= rsp_err;
            end
            // The IFU only "loses" when it is waiting and the LSU is granted.
            if (!ifu_req_valid || grant_ifu) begin
                streak <= '0;
            end else if (grant_lsu && (streak != STREAK_MAX)) begin
                streak <= streak + SW'(1);
            end
        end
    end

    // ---- stage p1/p2: response routing ----
    always_comb begin
        rsp_data = '0;
        rsp_err  = 1'b0;
        if (state_p1 == RSP) begin
            rsp_data = zero_p1 ? '0 : ram_dout;
            rsp_err  = err_p1;
        end else if (state_p1 == HOLD) begin
            rsp_data = hold_data_p2;
            rsp_err  = hold_err_p2;
        end
    end

    assign ifu_rsp_valid = vld_p1 && !owner_p1;
    assign lsu_rsp_valid = vld_p1 && owner_p1;
    assign ifu_rsp_instr = ifu_rsp_valid ? rsp_data : '0;
    assign ifu_rsp_err   = ifu_rsp_valid && rsp_err;
    assign lsu_rsp_rdata = lsu_rsp_valid ? rsp_data : '0;
    assign lsu_rsp_err   = lsu_rsp_valid && rsp_err;

    // MW documents the byte-lane count of the mask ports.
    initial assert (MW * 8 == DW);

endmodule

// File: tb/tb_itcm_ctrl.sv
module tb_itcm_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ifu_req_valid;
    logic        ifu_req_ready;
    logic [31:0] ifu_req_pc;
    logic        ifu_rsp_valid;
    logic        ifu_rsp_ready;
    logic [31:0] ifu_rsp_instr;
    logic        ifu_rsp_err;
    logic        lsu_req_valid;
    logic        lsu_req_ready;
    logic [31:0] lsu_req_addr;
    logic        lsu_req_write;
    logic [31:0] lsu_req_wdata;
    logic [3:0]  lsu_req_wmask;
    logic        lsu_rsp_valid;
    logic        lsu_rsp_ready;
    logic [31:0] lsu_rsp_rdata;
    logic        lsu_rsp_err;
    logic        ram_cs;
    logic        ram_we;
    logic [11:0] ram_addr;
    logic [3:0]  ram_wem;
    logic [31:0] ram_din;
    logic [31:0] ram_dout;

    itcm_ctrl #(.PC_SIZE(32), .DW(32), .RAM_AW(12), .STARVE_MAX(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_req_pc(ifu_req_pc),
        .ifu_rsp_valid(ifu_rsp_valid), .ifu_rsp_ready(ifu_rsp_ready),
        .ifu_rsp_instr(ifu_rsp_instr), .ifu_rsp_err(ifu_rsp_err),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_req_addr(lsu_req_addr),
        .lsu_req_write(lsu_req_write), .lsu_req_wdata(lsu_req_wdata), .lsu_req_wmask(lsu_req_wmask),
        .lsu_rsp_valid(lsu_rsp_valid), .lsu_rsp_ready(lsu_rsp_ready),
        .lsu_rsp_rdata(lsu_rsp_rdata), .lsu_rsp_err(lsu_rsp_err),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wem(ram_wem),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // SRAM model: word i holds 0xA500_0000 | i, except word 8 (byte 0x20).
    logic [31:0] mem [4096];
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 32'hA500_0000 | 32'(i);
            mem[8] <= 32'h1122_3344;
        end else if (ram_cs) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++)
                    if (ram_wem[b]) mem[ram_addr][8*b +: 8] <= ram_din[8*b +: 8];
            end else begin
                ram_dout <= mem[ram_addr];
            end
        end
    end

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic        irr;
        logic        lv;
        logic [31:0] la;
        logic        lw;
        logic [31:0] wd;
        logic [3:0]  wm;
        logic        lrr;
        logic        e_irdy;
        logic        e_lrdy;
        logic        e_cs;
        logic        e_we;
        logic [11:0] e_addr;
        logic        e_iv;
        logic [31:0] e_instr;
        logic        e_ierr;
        logic        e_lv;
        logic [31:0] e_ldata;
        logic        e_lerr;
    } vec_t;

    function automatic vec_t mk(
        input int iv, input logic [31:0] pc, input int irr,
        input int lv, input logic [31:0] la, input int lw, input logic [31:0] wd,
        input int wm, input int lrr,
        input int e_irdy, input int e_lrdy, input int e_cs, input int e_we, input int e_addr,
        input int e_iv, input logic [31:0] e_instr, input int e_ierr,
        input int e_lv, input logic [31:0] e_ldata, input int e_lerr);
        vec_t v;
        v.iv = iv[0];       v.pc = pc;          v.irr = irr[0];
        v.lv = lv[0];       v.la = la;          v.lw = lw[0];
        v.wd = wd;          v.wm = wm[3:0];     v.lrr = lrr[0];
        v.e_irdy = e_irdy[0]; v.e_lrdy = e_lrdy[0]; v.e_cs = e_cs[0];
        v.e_we = e_we[0];   v.e_addr = e_addr[11:0];
        v.e_iv = e_iv[0];   v.e_instr = e_instr; v.e_ierr = e_ierr[0];
        v.e_lv = e_lv[0];   v.e_ldata = e_ldata; v.e_lerr = e_lerr[0];
        return v;
    endfunction

    localparam int NV = 34;
    vec_t tbl [NV];
    vec_t v;
    int   n_chk = 0;
    int   n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t x);
        ifu_req_valid = x.iv;  ifu_req_pc = x.pc;   ifu_rsp_ready = x.irr;
        lsu_req_valid = x.lv;  lsu_req_addr = x.la; lsu_req_write = x.lw;
        lsu_req_wdata = x.wd;  lsu_req_wmask = x.wm; lsu_rsp_ready = x.lrr;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        //          iv pc        irr lv la       lw wd            wm lrr | irdy lrdy cs we addr | iv instr        ierr | lv ldata        lerr
        tbl[0]  = mk(1, 32'h4,    1, 0, 0,       0, 0,            0, 1,    1, 0, 1, 0, 1,   0, 0,            0,   0, 0,            0);
        tbl[1]  = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   1, 32'hA5000001, 0,   0, 0,            0);
        tbl[2]  = mk(1, 32'h0,    1, 0, 0,       0, 0,            0, 1,    1, 0, 1, 0, 0,   0, 0,            0,   0, 0,            0);
        tbl[3]  = mk(1, 32'h4,    1, 0, 0,       0, 0,            0, 1,    1, 0, 1, 0, 1,   1, 32'hA5000000, 0,   0, 0,            0);
        tbl[4]  = mk(1, 32'h8,    1, 0, 0,       0, 0,            0, 1,    1, 0, 1, 0, 2,   1, 32'hA5000001, 0,   0, 0,            0);
        tbl[5]  = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   1, 32'hA5000002, 0,   0, 0,            0);
        tbl[6]  = mk(1, 32'h10,   0, 0, 0,       0, 0,            0, 1,    1, 0, 1, 0, 4,   0, 0,            0,   0, 0,            0);
        tbl[7]  = mk(1, 32'h14,   0, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   1, 32'hA5000004, 0,   0, 0,            0);
        tbl[8]  = tbl[7];
        tbl[9]  = tbl[7];
        tbl[10] = tbl[7];
        tbl[11] = mk(1, 32'h14,   1, 0, 0,       0, 0,            0, 1,    1, 0, 1, 0, 5,   1, 32'hA5000004, 0,   0, 0,            0);
        tbl[12] = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   1, 32'hA5000005, 0,   0, 0,            0);
        tbl[13] = mk(1, 32'h0,    1, 1, 32'h4,   0, 0,            0, 1,    0, 1, 1, 0, 1,   0, 0,            0,   0, 0,            0);
        tbl[14] = mk(1, 32'h0,    1, 1, 32'h4,   0, 0,            0, 1,    0, 1, 1, 0, 1,   0, 0,            0,   1, 32'hA5000001, 0);
        tbl[15] = mk(1, 32'h0,    1, 1, 32'h4,   0, 0,            0, 1,    1, 0, 1, 0, 0,   0, 0,            0,   1, 32'hA5000001, 0);
        tbl[16] = mk(1, 32'h0,    1, 1, 32'h4,   0, 0,            0, 1,    0, 1, 1, 0, 1,   1, 32'hA5000000, 0,   0, 0,            0);
        tbl[17] = mk(1, 32'h0,    1, 1, 32'h4,   0, 0,            0, 1,    0, 1, 1, 0, 1,   0, 0,            0,   1, 32'hA5000001, 0);
        tbl[18] = mk(1, 32'h0,    1, 1, 32'h4,   0, 0,            0, 1,    1, 0, 1, 0, 0,   0, 0,            0,   1, 32'hA5000001, 0);
        tbl[19] = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   1, 32'hA5000000, 0,   0, 0,            0);
        tbl[20] = mk(1, 32'h4000, 1, 0, 0,       0, 0,            0, 1,    1, 0, 0, 0, 0,   0, 0,            0,   0, 0,            0);
        tbl[21] = mk(0, 0,        1, 1, 32'h6,   0, 0,            0, 1,    0, 1, 0, 0, 0,   1, 0,            1,   0, 0,            0);
        tbl[22] = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   0, 0,            0,   1, 0,            1);
        tbl[23] = mk(0, 0,        1, 1, 32'h20,  1, 32'hAABBCCDD, 5, 1,    0, 1, 1, 1, 8,   0, 0,            0,   0, 0,            0);
        tbl[24] = mk(0, 0,        1, 1, 32'h20,  0, 0,            0, 1,    0, 1, 1, 0, 8,   0, 0,            0,   1, 0,            0);
        tbl[25] = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   0, 0,            0,   1, 32'h11BB33DD, 0);
        tbl[26] = mk(0, 0,        1, 1, 32'h20,  1, 32'hFFFFFFFF, 0, 1,    0, 1, 1, 1, 8,   0, 0,            0,   0, 0,            0);
        tbl[27] = mk(0, 0,        1, 1, 32'h20,  0, 0,            0, 1,    0, 1, 1, 0, 8,   0, 0,            0,   1, 0,            0);
        tbl[28] = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   0, 0,            0,   1, 32'h11BB33DD, 0);
        tbl[29] = mk(0, 0,        1, 1, 32'h24,  0, 0,            0, 0,    0, 1, 1, 0, 9,   0, 0,            0,   0, 0,            0);
        tbl[30] = mk(0, 0,        1, 1, 32'h0,   0, 0,            0, 0,    0, 0, 0, 0, 0,   0, 0,            0,   1, 32'hA5000009, 0);
        tbl[31] = tbl[30];
        tbl[32] = mk(0, 0,        1, 1, 32'h0,   0, 0,            0, 1,    0, 1, 1, 0, 0,   0, 0,            0,   1, 32'hA5000009, 0);
        tbl[33] = mk(0, 0,        1, 0, 0,       0, 0,            0, 1,    0, 0, 0, 0, 0,   0, 0,            0,   1, 32'hA5000000, 0);

        // Reset held for 3 cycles with a fetch pending.
        rst_n = 1'b0;
        drive(mk(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            ifu_req_valid = 1'b1; ifu_req_pc = 32'h4; lsu_req_valid = 1'b1;
            #3;
            chk($sformatf("rst%0d ifu_req_ready", c), 32'(ifu_req_ready), 0);
            chk($sformatf("rst%0d lsu_req_ready", c), 32'(lsu_req_ready), 0);
            chk($sformatf("rst%0d ram_cs", c), 32'(ram_cs), 0);
            chk($sformatf("rst%0d ifu_rsp_valid", c), 32'(ifu_rsp_valid), 0);
            chk($sformatf("rst%0d lsu_rsp_valid", c), 32'(lsu_rsp_valid), 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            v = tbl[i];
            drive(v);
            #3;
            chk($sformatf("r%0d ifu_req_ready", i), 32'(ifu_req_ready), 32'(v.e_irdy));
            chk($sformatf("r%0d lsu_req_ready", i), 32'(lsu_req_ready), 32'(v.e_lrdy));
            chk($sformatf("r%0d ram_cs", i), 32'(ram_cs), 32'(v.e_cs));
            chk($sformatf("r%0d ifu_rsp_valid", i), 32'(ifu_rsp_valid), 32'(v.e_iv));
            chk($sformatf("r%0d ifu_rsp_instr", i), ifu_rsp_instr, v.e_instr);
            chk($sformatf("r%0d ifu_rsp_err", i), 32'(ifu_rsp_err), 32'(v.e_ierr));
            chk($sformatf("r%0d lsu_rsp_valid", i), 32'(lsu_rsp_valid), 32'(v.e_lv));
            chk($sformatf("r%0d lsu_rsp_rdata", i), lsu_rsp_rdata, v.e_ldata);
            chk($sformatf("r%0d lsu_rsp_err", i), 32'(lsu_rsp_err), 32'(v.e_lerr));
            if (v.e_cs) begin
                chk($sformatf("r%0d ram_addr", i), 32'(ram_addr), 32'(v.e_addr));
                chk($sformatf("r%0d ram_we", i), 32'(ram_we), 32'(v.e_we));
            end
            if (v.e_we) begin
                chk($sformatf("r%0d ram_wem", i), 32'(ram_wem), 32'(v.wm));
                chk($sformatf("r%0d ram_din", i), ram_din, v.wd);
            end
            @(posedge clk); #1;
        end

        // Reset in the middle of a fetch response drops it; nothing follows release.
        drive(mk(1, 32'h8, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        #3;
        chk("mid ram_cs", 32'(ram_cs), 1);
        @(posedge clk); #1;
        ifu_req_valid = 1'b0;
        #1;
        chk("mid ifu_rsp_valid before", 32'(ifu_rsp_valid), 1);
        chk("mid ifu_rsp_instr before", ifu_rsp_instr, 32'hA5000002);
        rst_n = 1'b0;
        #1;
        chk("mid ifu_rsp_valid in reset", 32'(ifu_rsp_valid), 0);
        chk("mid ifu_rsp_instr in reset", ifu_rsp_instr, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #3;
            chk($sformatf("post%0d ifu_rsp_valid", c), 32'(ifu_rsp_valid), 0);
            chk($sformatf("post%0d lsu_rsp_valid", c), 32'(lsu_rsp_valid), 0);
            chk($sformatf("post%0d ram_cs", c), 32'(ram_cs), 0);
            @(posedge clk); #1;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
